// File: rtl/fp_mult_sched.sv
// Round-robin scheduler that shares one fixed-latency pipelined FP multiplier core
// among N_REQ requesters, each with one operation in flight and a private result register.
module fp_mult_sched #(
    parameter int WIDTH    = 32,
    parameter int N_REQ    = 4,
    parameter int MULT_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*2-1:0]     req_rnd,
    output logic [WIDTH-1:0]       mult_a,
    output logic [WIDTH-1:0]       mult_b,
    output logic [1:0]             mult_rnd,
    output logic                   mult_issue,
    input  logic [WIDTH-1:0]       mult_result,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [N_REQ*WIDTH-1:0] resp_data,
    output logic                   busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INFLIGHT = 2'd1,
        ST_HOLD     = 2'd2
    } req_state_t;

    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    ptr_next;
    logic             started_reg;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] grant_vec;
    logic [N_REQ-1:0] capture_vec;
    logic             grant_any;
    logic [PW-1:0]    grant_idx;
    logic [MULT_LAT:0] tag_vld_reg;
    logic [PW-1:0]    tag_reg [MULT_LAT+1];
    logic [WIDTH-1:0] mult_a_reg;
    logic [WIDTH-1:0] mult_b_reg;
    logic [1:0]       mult_rnd_reg;
    logic             mult_issue_reg;

    assign cand = req_valid & req_ready;

    // Search upward from the pointer, wrapping modulo N_REQ; first candidate wins.
    always_comb begin
        logic [PW:0] sum;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        sum       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_reg} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            if (!grant_any && cand[sum[PW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = sum[PW-1:0];
            end
        end
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_reg    <= 1'b0;
            ptr_reg        <= '0;
            mult_issue_reg <= 1'b0;
            mult_a_reg     <= '0;
            mult_b_reg     <= '0;
            mult_rnd_reg   <= '0;
            tag_vld_reg    <= '0;
            for (int k = 0; k <= MULT_LAT; k++) begin
                tag_reg[k] <= '0;
            end
        end else begin
            started_reg    <= 1'b1;
            ptr_reg        <= ptr_next;
            mult_issue_reg <= grant_any;
            if (grant_any) begin
                mult_a_reg   <= req_a[grant_idx*WIDTH +: WIDTH];
                mult_b_reg   <= req_b[grant_idx*WIDTH +: WIDTH];
                mult_rnd_reg <= req_rnd[grant_idx*2 +: 2];
            end
            // Tag pipe mirrors the core latency plus the input register stage.
            tag_vld_reg <= {tag_vld_reg[MULT_LAT-1:0], grant_any};
            tag_reg[0]  <= grant_idx;
            for (int k = 1; k <= MULT_LAT; k++) begin
                tag_reg[k] <= tag_reg[k-1];
            end
        end
    end

    always_comb begin
        capture_vec = '0;
        if (tag_vld_reg[MULT_LAT]) begin
            capture_vec[tag_reg[MULT_LAT]] = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            req_state_t       state_reg;
            req_state_t       state_next;
            logic [WIDTH-1:0] data_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg <= ST_IDLE;
                    data_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    if (capture_vec[gi]) begin
                        data_reg <= mult_result;
                    end
                end
            end

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    ST_IDLE:     if (grant_vec[gi])   state_next = ST_INFLIGHT;
                    ST_INFLIGHT: if (capture_vec[gi]) state_next = ST_HOLD;
                    ST_HOLD:     if (resp_ready[gi])  state_next = ST_IDLE;
                    default:                          state_next = ST_IDLE;
                endcase
            end

            // started_reg keeps req_ready low until the first edge after reset release.
            assign req_ready[gi]                  = started_reg && (state_reg == ST_IDLE);
            assign resp_valid[gi]                 = (state_reg == ST_HOLD);
            assign resp_data[gi*WIDTH +: WIDTH]   = data_reg;
        end
    endgenerate

    assign mult_a     = mult_a_reg;
    assign mult_b     = mult_b_reg;
    assign mult_rnd   = mult_rnd_reg;
    assign mult_issue = mult_issue_reg;
    assign busy       = mult_issue_reg | (|tag_vld_reg);

endmodule

// File: tb/tb_fp_mult_sched.sv
// Scoreboard bench for fp_mult_sched: a request-level model predicts grants and results,
// a separate monitor compares DUT outputs on every falling edge.
module tb_fp_mult_sched;

    localparam int W = 32;
    localparam int N = 4;
    localparam int L = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*2-1:0] req_rnd;
    logic [W-1:0]   mult_a;
    logic [W-1:0]   mult_b;
    logic [1:0]     mult_rnd;
    logic           mult_issue;
    logic [W-1:0]   mult_result;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready;
    logic [N*W-1:0] resp_data;
    logic           busy;

    always #5 clk = ~clk;

    fp_mult_sched #(.WIDTH(W), .N_REQ(N), .MULT_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
        .mult_a(mult_a), .mult_b(mult_b), .mult_rnd(mult_rnd), .mult_issue(mult_issue),
        .mult_result(mult_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy)
    );

    // Single-precision multiply for normal operands; rnd: 0 nearest, 1 zero, 2 +inf, 3 -inf.
    function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b, logic [1:0] rnd);
        logic s;
        int ea, eb, e;
        logic [47:0] p;
        logic [22:0] m;
        logic [23:0] rem;
        logic [23:0] mr;
        logic inc;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (p[47]) begin
            m = p[46:24]; rem = p[23:0]; e = e + 1;
        end else begin
            m = p[45:23]; rem = {p[22:0], 1'b0};
        end
        case (rnd)
            2'd0:    inc = rem[23];
            2'd1:    inc = 1'b0;
            2'd2:    inc = !s && (rem != 0);
            default: inc = s && (rem != 0);
        endcase
        mr = {1'b0, m} + 24'(inc);
        if (mr[23]) begin
            m = 23'd0; e = e + 1;
        end else begin
            m = mr[22:0];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m};
    endfunction

    // Stand-in core: inputs sampled one edge after issue, result valid two edges later.
    logic [W-1:0] core_s1, core_s2;
    always @(posedge clk) begin
        core_s1 <= fmul(mult_a, mult_b, mult_rnd);
        core_s2 <= core_s1;
    end
    assign mult_result = core_s2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rnd;
    } op_t;

    op_t         issue_q[$];
    int          m_state[N];   // 0 idle, 1 in flight, 2 holding result
    int          m_cnt[N];
    int          m_ptr;
    bit          m_started;
    bit          m_issue;
    logic [31:0] exp_resp[N];

    logic [N-1:0] op_valid;
    logic [31:0]  op_a[N];
    logic [31:0]  op_b[N];
    logic [1:0]   op_rnd[N];
    logic [N-1:0] gen_en;
    logic [N-1:0] rr_hold;
    bit           rr_rand;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_fp();
        if ($urandom % 8 == 0) return 32'd0;
        return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    task automatic set_op(int i, logic [31:0] a, logic [31:0] b, logic [1:0] r);
        op_valid[i] = 1'b1;
        op_a[i]     = a;
        op_b[i]     = b;
        op_rnd[i]   = r;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!op_valid[i] && gen_en[i] && ($urandom % 3 == 0))
                set_op(i, rand_fp(), rand_fp(), 2'($urandom));
            req_valid[i]      = op_valid[i];
            req_a[i*W +: W]   = op_a[i];
            req_b[i*W +: W]   = op_b[i];
            req_rnd[i*2 +: 2] = op_rnd[i];
            resp_ready[i]     = rr_hold[i] ? 1'b0 : (rr_rand ? 1'($urandom) : 1'b1);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0;
            m_cnt[i]   = 0;
        end
        m_ptr     = 0;
        m_started = 1'b0;
        m_issue   = 1'b0;
        op_valid  = '0;
        issue_q.delete();
    endtask

    // Applies what the edge just passed did, using the inputs present at that edge.
    task automatic model_step();
        int g;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx] && m_state[idx] == 0 && m_started) g = idx;
        end
        for (int i = 0; i < N; i++) begin
            if (m_state[i] == 2 && resp_ready[i]) begin
                m_state[i] = 0;
            end else if (m_state[i] == 1) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) m_state[i] = 2;
            end
        end
        if (g >= 0) begin
            m_state[g]  = 1;
            m_cnt[g]    = L + 1;
            issue_q.push_back('{a: op_a[g], b: op_b[g], rnd: op_rnd[g]});
            exp_resp[g] = fmul(op_a[g], op_b[g], op_rnd[g]);
            m_ptr       = (g + 1) % N;
            op_valid[g] = 1'b0;
            m_issue     = 1'b1;
        end else begin
            m_issue = 1'b0;
        end
        m_started = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) model_step();
        drive();
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        model_reset();
        drive();
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mult_issue", mult_issue, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_mult_b", mult_b, 0);
        chk("rst_mult_rnd", mult_rnd, 0);
        chk("rst_resp_data", resp_data, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        chk("rel_req_ready", req_ready, {N{1'b1}});
    endtask

    // Monitor: compares every cycle against the model and pops the issue scoreboard.
    initial begin
        logic [N-1:0] er, ev;
        bit eb;
        op_t o;
        forever begin
            @(negedge clk);
            er = '0; ev = '0; eb = 1'b0;
            for (int i = 0; i < N; i++) begin
                er[i] = (m_state[i] == 0) && m_started;
                ev[i] = (m_state[i] == 2);
                eb    = eb | (m_state[i] == 1);
            end
            chk("req_ready", req_ready, er);
            chk("resp_valid", resp_valid, ev);
            chk("busy", busy, eb);
            chk("mult_issue", mult_issue, m_issue);
            if (mult_issue) begin
                if (issue_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL issue_unexpected: got op %h/%h expected none at %0t", mult_a, mult_b, $time);
                end else begin
                    o = issue_q.pop_front();
                    chk("issue_op", {mult_a, mult_b, mult_rnd}, {o.a, o.b, o.rnd});
                end
            end
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i] && m_state[i] == 2)
                    chk($sformatf("resp_data%0d", i), resp_data[i*W +: W], exp_resp[i]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1);
    end

    initial begin
        logic [31:0] fa[N];
        int issues;
        rst = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_rnd = '0; resp_ready = '0;
        gen_en = '0; rr_hold = '0; rr_rand = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_rnd[i] = '0; exp_resp[i] = '0;
        end
        model_reset();
        @(posedge clk);
        #1;
        assert_reset();
        release_reset();

        // Single request: 1.5 * 2.0 with the response held off for a few cycles.
        rr_hold[0] = 1'b1;
        set_op(0, 32'h3FC00000, 32'h40000000, 2'd0);
        drive();
        step();
        chk("single_issue", mult_issue, 1);
        chk("single_mult_a", mult_a, 32'h3FC00000);
        chk("single_mult_b", mult_b, 32'h40000000);
        step(); step();
        chk("single_early_valid", resp_valid[0], 0);
        step();
        chk("single_valid", resp_valid[0], 1);
        chk("single_data", resp_data[W-1:0], 32'h40400000);
        chk("single_ready_held", req_ready[0], 0);
        step(); step();
        chk("single_data_stable", resp_data[W-1:0], 32'h40400000);
        rr_hold[0] = 1'b0;
        drive();
        step();
        chk("single_after_hs_valid", resp_valid[0], 0);
        chk("single_after_hs_ready", req_ready[0], 1);

        // Pointer skip: move pointer to 2 via requester 1, then 1 and 3 compete.
        set_op(1, 32'h40A00000, 32'h3F000000, 2'd1);
        drive();
        repeat (6) step();
        set_op(1, 32'h41200000, 32'h40400000, 2'd2);
        set_op(3, 32'h41800000, 32'hC0000000, 2'd3);
        drive();
        step();
        chk("skip_first_3", mult_a, 32'h41800000);
        step();
        chk("skip_then_1", mult_a, 32'h41200000);
        repeat (6) step();

        // Issue to 0 and 1 on the same edges where requester 3's result is captured.
        assert_reset();
        release_reset();
        set_op(3, 32'h40400000, 32'h40400000, 2'd0);
        drive();
        step();
        step();
        set_op(0, 32'h40800000, 32'h3FC00000, 2'd0);
        set_op(1, 32'hBF800000, 32'h42000000, 2'd0);
        drive();
        step();
        step();
        chk("overlap_cap3", resp_valid[3], 1);
        chk("overlap_issue1", mult_a, 32'hBF800000);
        repeat (6) step();

        // Fairness: everyone valid out of reset, grants in order 0..3.
        gen_en = '1;
        assert_reset();
        for (int i = 0; i < N; i++) begin
            fa[i] = rand_fp() | 32'h00400000;
            set_op(i, fa[i], rand_fp(), 2'($urandom));
        end
        drive();
        release_reset();
        for (int k = 0; k < N; k++) begin
            step();
            chk($sformatf("fair_grant%0d", k), mult_a, fa[k]);
        end
        repeat (30) step();

        // Backpressure on requester 2 while the others keep going.
        gen_en = 4'b1011;
        assert_reset();
        release_reset();
        rr_hold[2] = 1'b1;
        set_op(2, 32'h00000000, 32'h3F800000, 2'($urandom));
        drive();
        for (int t = 0; t < 30 && !resp_valid[2]; t++) step();
        chk("bp_reached_hold", resp_valid[2], 1);
        issues = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            chk("bp_valid", resp_valid[2], 1);
            chk("bp_data", resp_data[2*W +: W], 32'h00000000);
            chk("bp_ready", req_ready[2], 0);
            if (mult_issue) issues++;
        end
        chk("bp_others_served", issues > 0, 1);
        rr_hold[2] = 1'b0;

        // Reset one cycle after two grants: in-flight work is dropped.
        gen_en = '0;
        assert_reset();
        release_reset();
        set_op(0, 32'h3F800000, 32'h40000000, 2'd0);
        set_op(1, 32'h40000000, 32'h40000000, 2'd0);
        drive();
        step(); step();
        step();
        chk("midflight_busy", busy, 1);
        assert_reset();
        release_reset();
        repeat (6) step();
        chk("midflight_no_resp", resp_valid, 0);
        chk("midflight_idle", busy, 0);

        // Random traffic with random consumer backpressure.
        gen_en  = '1;
        rr_rand = 1'b1;
        repeat (3000) step();

        gen_en  = '0;
        rr_rand = 1'b0;
        repeat (20) step();
        chk("drain_issue_q", 64'(issue_q.size()), 0);
        chk("drain_busy", busy, 0);
        chk("drain_ready", req_ready, {N{1'b1}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_mult_sched.md
Name: fp_mult_sched

Overview:
- Shares one pipelined 32-bit FP multiplier between N_REQ requesters.
- Round-robin arbitration, one issue per cycle at most.
- Each requester has at most one operation in flight; its result is held in a per-requester register until the requester consumes it.
- Sits between the datapath clients and the multiplier core; this block alone drives the core's A/B/rnd inputs.

Parameters:
WIDTH, 32, operand/result width
N_REQ, 4, number of requesters (2..8)
MULT_LAT, 2, clock edges from the core sampling its inputs to its result being valid (fixed, no stall)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  N_REQ  requester i has an operation
req_ready  output  N_REQ  requester i may hand over an operation
req_a  input  N_REQ*WIDTH  operand A, slice i
req_b  input  N_REQ*WIDTH  operand B, slice i
req_rnd  input  N_REQ*2  rounding mode, slice i
mult_a  output  WIDTH  to core A
mult_b  output  WIDTH  to core B
mult_rnd  output  2  to core rnd
mult_issue  output  1  core inputs hold a new operation this cycle
mult_result  input  WIDTH  core result
resp_valid  output  N_REQ  result for requester i held
resp_ready  input  N_REQ  requester i consumes its result
resp_data  output  N_REQ*WIDTH  result, slice i
busy  output  1  any operation issued or in flight

Behaviour:
- Reset (rst=0, asynchronous) clears the following:
  - req_ready, resp_valid, mult_issue and busy all go to 0.
  - mult_a/mult_b/mult_rnd/resp_data go to 0.
  - Round-robin pointer goes to 0.
  - All in-flight tags are cleared; in-flight operations are discarded with no response.
- The first cycle after reset release shows req_ready all 1.
- Per-requester state:
  - IDLE: req_ready[i]=1.
  - INFLIGHT: accepted, result not yet captured.
  - HOLD: resp_valid[i]=1.
- Transitions:
  - IDLE->INFLIGHT on grant.
  - INFLIGHT->HOLD on result capture.
  - HOLD->IDLE on resp_valid[i]&resp_ready[i] at a clock edge.
  - req_ready[i]=1 only in IDLE, so a new request is accepted no earlier than the cycle after the response handshake.
- Arbitration (combinational):
  - Candidates are req_valid[i]&req_ready[i].
  - Search starts at pointer p and proceeds upward modulo N_REQ; the first candidate is granted.
  - The grant is the accept edge E0. On grant to i, p <= (i+1) mod N_REQ.
  - With no candidates, p holds.
  - At most one grant per cycle.
  - A requester that is ready but not granted is not accepted; it must hold req_valid and its operands.
- Issue:
  - At E0, req_a/req_b/req_rnd slice i are registered into mult_a/mult_b/mult_rnd, mult_issue<=1, and tag i is pushed into a MULT_LAT+1-deep tag/valid shift register.
  - With no grant, mult_issue<=0 and mult_a/b/rnd hold their values.
- Capture:
  - When the tag-pipe tail is valid with tag i, mult_result is written into resp_data slice i and resp_valid[i]<=1.
  - This happens at edge E0+MULT_LAT+1, so resp_valid[i] is first visible MULT_LAT+1 cycles after the accept edge.
- resp_data slice i is stable while resp_valid[i]=1. It holds its last value after the handshake.
- busy=1 whenever mult_issue or any tag-pipe entry is valid.
- Simultaneous events:
  - A capture for requester i and a handshake for requester j≠i in the same cycle are independent.
  - Capture and handshake for the same i cannot coincide (one outstanding op per requester).
  - Issue and capture in the same cycle are both performed.
- No backpressure into the core: results are always captured. This is guaranteed because HOLD slots are reserved at grant.
- The rnd value is forwarded unmodified. The block does no FP arithmetic, so special values pass through as the core produces them.

Test Plan:
- Single request, N_REQ=4, MULT_LAT=2, req 0 with A=0x3FC00000, B=0x40000000, rnd=0 accepted at E0 -> mult_issue=1 after E0, resp_valid[0]=1 after E3, resp_data[0]=0x40400000, req_ready[0]=0 until the edge after resp handshake.
- Fairness: all req_valid=1 from reset, resp_ready=all 1 -> grants in order 0,1,2,3 on four consecutive edges, mult_issue high 4 cycles, then requester 0 re-granted only after its response handshake; pointer wraps 3->0.
- Backpressure: resp_ready[2]=0 for 10 cycles after result (A=0x00000000, B=0x3F800000) -> resp_valid[2] held 1, resp_data[2]=0x00000000 stable, req_ready[2]=0, other requesters keep being served.
- Pointer skip: only req 1 and 3 valid, p=2 -> 3 granted first, then 1; p ends at 2.
- Reset mid-flight: assert rst=0 one cycle after two grants -> all outputs 0 immediately, no resp_valid after release, req_ready all 1, busy=0.
- Back-to-back issue/capture overlap: grants on consecutive edges to 0 and 1 while capture for 3 occurs -> each resp_data slice gets its own result, no cross-tagging.
